// File: rtl/imem_fetch_if.sv
// Fetch request/response bundle between the PC stage and the instruction memory.
//   req_valid/req_ready/req_addr : fetch address channel (PC stage -> memory)
//   rsp_valid/rsp_ready          : response handshake (memory -> PC stage)
//   rsp_instr/rsp_addr/rsp_err   : response payload
// master = PC stage (fetch requester), slave = instruction memory responder.
interface imem_fetch_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
   );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder. Accepts fetch addresses, reads a word-addressed
// store and returns in-order responses through a small FIFO. flush drops every
// in-flight and buffered fetch.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   flush             : discard all in-flight and buffered responses
//   bus (slave)       : request/response channels, see imem_fetch_if
//   wr_en/wr_addr/wr_data : store load port (byte address, bits [1:0] ignored)
module imem_fetch_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   imem_fetch_if.slave bus,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
   } entry_t;

   logic [31:0] store [DEPTH_WORDS];

   logic          req_ready;
   logic          accept;
   logic          pop;
   logic          push;
   entry_t        in_entry;
   entry_t        push_entry;
   logic [CW-1:0] outstanding_q, outstanding_d;

   entry_t        fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] fifo_cnt_q;
   logic          rsp_valid;
   entry_t        head;

   logic          unused_wr_lsb;
   assign unused_wr_lsb = ^wr_addr[1:0];

   // ---------------- request side ----------------
   assign req_ready     = !reset && !flush && (outstanding_q < CW'(FIFO_DEPTH));
   assign bus.req_ready = req_ready;
   assign accept        = bus.req_valid && req_ready;

   // Store read is combinational in the accept cycle, so a same-cycle write
   // (which lands at the edge) is not visible to this fetch.
   always_comb begin
      in_entry.addr  = bus.req_addr;
      in_entry.err   = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:AW+2] != '0);
      in_entry.instr = in_entry.err ? NOP : store[bus.req_addr[AW+1:2]];
   end

   // ---------------- store load port ----------------
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr[31:AW+2] == '0)) begin
         store[wr_addr[AW+1:2]] <= wr_data;
      end
   end

   // ---------------- latency pipeline ----------------
   // LATENCY-1 register stages feed the FIFO; the FIFO write adds the last cycle.
   if (LATENCY == 1) begin : g_direct
      assign push       = accept;
      assign push_entry = in_entry;
   end else begin : g_pipe
      logic [LATENCY-2:0] vld_q;
      entry_t             ent_q [LATENCY-1];

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < LATENCY - 1; i++) begin
               vld_q[i] <= vld_q[i-1];
            end
         end
      end

      always_ff @(posedge clk) begin
         ent_q[0] <= in_entry;
         for (int i = 1; i < LATENCY - 1; i++) begin
            ent_q[i] <= ent_q[i-1];
         end
      end

      assign push       = vld_q[LATENCY-2];
      assign push_entry = ent_q[LATENCY-2];
   end

   // ---------------- outstanding count ----------------
   // Pipeline entries plus FIFO occupancy; bounding it at FIFO_DEPTH means
   // every in-flight fetch is guaranteed a FIFO slot.
   always_comb begin
      outstanding_d = outstanding_q;
      unique case ({accept, pop})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

   // ---------------- response FIFO ----------------
   assign rsp_valid = (fifo_cnt_q != '0);
   assign pop       = rsp_valid && bus.rsp_ready;
   assign head      = fifo_mem[rptr_q];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_mem[wptr_q] <= push_entry;
            wptr_q           <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // Payload is forced to zero while empty so idle/reset outputs are clean.
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_instr = rsp_valid ? head.instr : '0;
   assign bus.rsp_addr  = rsp_valid ? head.addr  : '0;
   assign bus.rsp_err   = rsp_valid ? head.err   : 1'b0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;
   localparam int DEPTH_WORDS = 256;
   localparam int LATENCY     = 2;
   localparam int FIFO_DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   imem_fetch_if bus_if ();

   imem_fetch_responder #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .LATENCY    (LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .bus    (bus_if),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model_mem [DEPTH_WORDS];
   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   bit          after_reset = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s cycle %0d: timed out", name, cyc);
   endtask

   // Reference model + scoreboard monitor. Outstanding fetches are simply the
   // entries in the scoreboard; each becomes visible LATENCY cycles after accept.
   always @(negedge clk) begin
      exp_t e;
      bit   exp_valid;
      if (reset) begin
         check("req_ready_in_reset", {31'b0, bus_if.req_ready}, 32'd0);
         sb.delete();
         after_reset = 1;
      end else begin
         if (after_reset) begin
            check("reset_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
            check("reset_rsp_instr", bus_if.rsp_instr, 32'd0);
            check("reset_rsp_addr", bus_if.rsp_addr, 32'd0);
            check("reset_rsp_err", {31'b0, bus_if.rsp_err}, 32'd0);
            after_reset = 0;
         end
         exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
         check("rsp_valid", {31'b0, bus_if.rsp_valid}, {31'b0, exp_valid});
         check("req_ready", {31'b0, bus_if.req_ready},
               {31'b0, (!flush && sb.size() < FIFO_DEPTH)});
         if (bus_if.rsp_valid && bus_if.rsp_ready) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_rsp");
            end else begin
               e = sb.pop_front();
               check("rsp_instr", bus_if.rsp_instr, e.instr);
               check("rsp_addr", bus_if.rsp_addr, e.addr);
               check("rsp_err", {31'b0, bus_if.rsp_err}, {31'b0, e.err});
            end
         end
         if (flush) begin
            sb.delete();
         end else if (bus_if.req_valid && bus_if.req_ready) begin
            e.addr  = bus_if.req_addr;
            e.err   = (bus_if.req_addr % 4 != 0) || (bus_if.req_addr / 4 >= DEPTH_WORDS);
            e.instr = e.err ? 32'h0000_0013 : model_mem[bus_if.req_addr / 4];
            e.due   = cyc + LATENCY;
            sb.push_back(e);
         end
      end
      // Store update after the read: same-cycle fetch sees old data.
      if (wr_en && (wr_addr / 4 < DEPTH_WORDS)) model_mem[wr_addr / 4] = wr_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int idx, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_addr = idx * 4;
      wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic send(input logic [31:0] addr);
      bit done = 0;
      bus_if.req_valid = 1'b1;
      bus_if.req_addr  = addr;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (bus_if.req_ready) done = 1;
         tick();
      end
      bus_if.req_valid = 1'b0;
      if (!done) fail_now("send_accept");
   endtask

   task automatic drain();
      bit done = 0;
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0) done = 1;
      end
      tick();
      if (!done) fail_now("drain");
   endtask

   initial begin
      int n_acc;
      int r;
      reset            = 1'b1;
      flush            = 1'b0;
      wr_en            = 1'b0;
      wr_addr          = '0;
      wr_data          = '0;
      bus_if.req_valid = 1'b0;
      bus_if.req_addr  = '0;
      bus_if.rsp_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      for (int i = 0; i < DEPTH_WORDS; i++) write_word(i, $urandom);
      write_word(0, 32'd11);
      write_word(1, 32'd22);
      write_word(2, 32'd33);
      write_word(3, 32'd44);

      // back-to-back fetches at full throughput
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(i * 4);
      drain();

      // backpressure: only FIFO_DEPTH fetches may be outstanding
      bus_if.rsp_ready = 1'b0;
      n_acc = 0;
      bus_if.req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus_if.req_addr = n_acc * 4;
         @(negedge clk);
         if (bus_if.req_ready) n_acc++;
         tick();
      end
      bus_if.req_valid = 1'b0;
      check("backpressure_accepts", n_acc, 32'd4);
      bus_if.rsp_ready = 1'b1;
      send(32'd16);
      send(32'd20);
      drain();

      // misaligned and out-of-range
      send(32'h2);
      send(DEPTH_WORDS * 4);
      drain();

      // flush with three outstanding
      bus_if.rsp_ready = 1'b0;
      send(32'h0);
      send(32'h4);
      send(32'hC);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus_if.rsp_ready = 1'b1;
      repeat (4) tick();
      send(32'h8);
      drain();

      // write and fetch of the same word in one cycle
      wr_en   = 1'b1;
      wr_addr = 32'h4;
      wr_data = 32'hAA;
      send(32'h4);
      wr_en = 1'b0;
      send(32'h4);
      drain();
      write_word(1, 32'd22);

      // reset with fetches pending and a response presented
      bus_if.rsp_ready = 1'b0;
      send(32'h0);
      send(32'h4);
      send(32'h8);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(i * 4);
      drain();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, 9);
         bus_if.req_valid = ($urandom_range(0, 3) != 0);
         if (r == 0)      bus_if.req_addr = $urandom_range(0, DEPTH_WORDS - 1) * 4 + $urandom_range(1, 3);
         else if (r == 1) bus_if.req_addr = $urandom | (DEPTH_WORDS * 4);
         else             bus_if.req_addr = $urandom_range(0, DEPTH_WORDS - 1) * 4;
         bus_if.rsp_ready = ($urandom_range(0, 2) != 0);
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_addr = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h400)
                                                : $urandom_range(0, DEPTH_WORDS * 4 - 1);
         wr_data = $urandom;
         flush   = ($urandom_range(0, 29) == 0);
         tick();
      end
      bus_if.req_valid = 1'b0;
      wr_en = 1'b0;
      flush = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
